// File: rtl/irq_timer_ctrl_pkg.sv
// Shared constants for the machine interrupt source block: bus offsets, mcause codes, FSM states.
package irq_timer_ctrl_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } irq_state_e;

  // Word-granular match; the low two byte-offset bits are ignored.
  function automatic logic addr_hit(logic [15:0] addr, logic [15:0] off);
    return addr[15:2] == off[15:2];
  endfunction

  function automatic logic [31:0] mk_cause(logic [3:0] code);
    return {1'b1, 27'b0, code};
  endfunction

endpackage

// File: rtl/irq_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module irq_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/irq_timer_ctrl.sv
// Machine-level interrupt sources (mtime/mtimecmp, msip, external IRQ) and the trap request
// handshake towards the exception unit.
module irq_timer_ctrl
  import irq_timer_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  input  logic              ext_irq,
  input  logic              mstatus_mie,
  input  logic [2:0]        mie_in,
  output logic [2:0]        mip_out,
  input  logic              irq_ack,
  input  logic              mret_in,
  output logic              interrupt,
  output logic [31:0]       irq_cause
);

  logic [31:0] cnt_q, cnt_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mtip_q, msip_pend_q;
  logic        meip_sync;
  logic        tick;
  logic [15:0] addr;
  logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
  logic [2:0]  pend;
  logic        take;
  irq_state_e  state_q;
  logic        irq_q;
  logic [31:0] cause_q;

  assign addr        = 16'(bus_addr);
  assign hit_msip    = addr_hit(addr, MSIP_OFF);
  assign hit_cmp_lo  = addr_hit(addr, MTIMECMP_LO_OFF);
  assign hit_cmp_hi  = addr_hit(addr, MTIMECMP_HI_OFF);
  assign hit_time_lo = addr_hit(addr, MTIME_LO_OFF);
  assign hit_time_hi = addr_hit(addr, MTIME_HI_OFF);

  assign tick = (cnt_q == PRESCALE - 32'd1);

  always_comb begin
    cnt_d      = tick ? 32'd0 : cnt_q + 32'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = rdata_q;
    // A bus write to either mtime half replaces the increment for that cycle.
    if (bus_we) begin
      if (hit_time_lo) mtime_d = {mtime_q[63:32], bus_wdata};
      if (hit_time_hi) mtime_d = {bus_wdata, mtime_q[31:0]};
      if (hit_cmp_lo)  mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
      if (hit_cmp_hi)  mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
      if (hit_msip)    msip_d = bus_wdata[0];
    end
    if (bus_re) begin
      rdata_d = 32'd0;
      if (hit_msip)    rdata_d = {31'd0, msip_q};
      if (hit_cmp_lo)  rdata_d = mtimecmp_q[31:0];
      if (hit_cmp_hi)  rdata_d = mtimecmp_q[63:32];
      if (hit_time_lo) rdata_d = mtime_q[31:0];
      if (hit_time_hi) rdata_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= 32'd0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      rdata_q     <= 32'd0;
      mtip_q      <= 1'b0;
      msip_pend_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      rdata_q     <= rdata_d;
      mtip_q      <= (mtime_q >= mtimecmp_q);
      msip_pend_q <= msip_q;
    end
  end

  irq_sync2 u_ext_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (ext_irq),
    .q_o    (meip_sync)
  );

  assign mip_out = {meip_sync, mtip_q, msip_pend_q};
  assign pend    = mip_out & mie_in;
  assign take    = mstatus_mie & (|pend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      irq_q   <= 1'b0;
      cause_q <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (take) begin
            state_q <= StReq;
            irq_q   <= 1'b1;
            if (pend[2])      cause_q <= mk_cause(CAUSE_MEI);
            else if (pend[0]) cause_q <= mk_cause(CAUSE_MSI);
            else              cause_q <= mk_cause(CAUSE_MTI);
          end
        end
        // Cause stays frozen here even if the pending set changes before the ack.
        StReq: begin
          if (irq_ack) begin
            state_q <= StWait;
            irq_q   <= 1'b0;
          end
        end
        StWait: begin
          if (mret_in) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus_rdata = rdata_q;
  assign interrupt = irq_q;
  assign irq_cause = cause_q;

endmodule
